mp_reg_file: RTL
================

MP_REG_FILE -- requirements
Module: mp_reg_file

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the bit width of each word.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 wr_en  in  1  SHALL request a write of w_data to w_addr.
REQ-006 w_addr  in  ADDR_WIDTH  SHALL give the write address.
REQ-007 w_data  in  DATA_WIDTH  SHALL give the write data.
REQ-008 rd_en_a, rd_en_b  in  1 each  SHALL request a read on port A / port B.
REQ-009 r_addr_a, r_addr_b  in  ADDR_WIDTH each  SHALL give the read addresses.
REQ-010 r_data_a, r_data_b  out  DATA_WIDTH each  SHALL carry the registered read data.
REQ-011 clr_req  in  1  SHALL request a full-array clear to zero.
REQ-012 busy  out  1  SHALL be high while the clear engine runs.
REQ-013 wr_drop  out  1  SHALL pulse high for one cycle when a write is rejected.

Function
REQ-014 FSM SHALL have two states: IDLE and CLEAR; an internal clear pointer clr_ptr of ADDR_WIDTH bits SHALL index the word being zeroed.
REQ-015 IDLE -> CLEAR SHALL occur on a clk edge where clr_req=1, with clr_ptr loaded to 0; clr_req in CLEAR SHALL be ignored.
REQ-016 In CLEAR, each cycle SHALL write 0 to array[clr_ptr] and increment clr_ptr; the cycle writing DEPTH-1 SHALL transition to IDLE, so CLEAR lasts exactly DEPTH cycles.
REQ-017 busy SHALL equal (state == CLEAR), registered.
REQ-018 In IDLE, wr_en=1 SHALL write w_data to array[w_addr] at the clk edge.
REQ-019 In CLEAR, wr_en=1 SHALL NOT modify the array and SHALL set wr_drop=1 on the following cycle; wr_drop SHALL be 0 otherwise.
REQ-020 Read latency SHALL be one cycle: r_data_x updates at the edge where rd_en_x=1, and SHALL hold its value when rd_en_x=0.
REQ-021 Write-first forwarding: in IDLE, if wr_en=1, rd_en_x=1 and r_addr_x==w_addr in the same cycle, r_data_x SHALL load w_data.
REQ-022 Both read ports SHALL operate independently and concurrently, including identical addresses.
REQ-023 In CLEAR, rd_en_x=1 SHALL load 0 into r_data_x regardless of address.
REQ-024 clr_ptr increment SHALL be modulo DEPTH; no out-of-range address SHALL exist.

Reset
REQ-025 rst_n=0 SHALL asynchronously force r_data_a=0, r_data_b=0, wr_drop=0, state=CLEAR, clr_ptr=0, busy=1.
REQ-026 After rst_n deasserts, the FSM SHALL complete a DEPTH-cycle clear before entering IDLE; array contents SHALL be all-zero thereafter.
REQ-027 rst_n asserted mid-CLEAR or mid-write SHALL restart the clear from clr_ptr=0.

Verification
REQ-028 Reset then wait: rst_n low 2 cycles, release -> busy=1 for exactly 16 cycles, then 0; reads of all 16 addresses return 0x00.
REQ-029 Write/read: IDLE, write 0xA5 to addr 3, next cycle rd_en_a with r_addr_a=3 -> r_data_a=0xA5 one cycle later.
REQ-030 Forwarding: same cycle wr_en, w_addr=7, w_data=0x3C, rd_en_b, r_addr_b=7 -> r_data_b=0x3C next cycle; port A reading addr 7 simultaneously also gets 0x3C.
REQ-031 Dropped write: clr_req pulse, then wr_en to addr 2 with 0xFF during busy -> wr_drop=1 one cycle, addr 2 reads 0x00 after busy falls.
REQ-032 Hold: rd_en_a=0 while addr changes and writes occur -> r_data_a unchanged.
REQ-033 Reset mid-clear: assert rst_n at clear cycle 8 -> busy stays 1, clear restarts, busy falls 16 cycles after release.

Source files
------------

// File: rtl/mp_reg_file.sv
// Two-read/one-write register file with a self-timed clear engine that zeroes every word.
// Latency: reads return one cycle after rd_en_x; a clear occupies exactly DEPTH cycles.
// Backpressure: none; writes issued while busy are discarded and flagged by a one-cycle wr_drop.
module mp_reg_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd_en_a,
  input  logic [ADDR_WIDTH-1:0] r_addr_a,
  input  logic                  rd_en_b,
  input  logic [ADDR_WIDTH-1:0] r_addr_b,
  output logic [DATA_WIDTH-1:0] r_data_a,
  output logic [DATA_WIDTH-1:0] r_data_b,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  wr_drop
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
  logic                    busy_q, busy_d;
  logic                    wr_drop_q, wr_drop_d;
  logic [DATA_WIDTH-1:0]   r_data_a_q, r_data_a_d;
  logic [DATA_WIDTH-1:0]   r_data_b_q, r_data_b_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    in_clear;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  assign in_clear = (state_q == CLEAR);

  // Next-state logic: IDLE waits for clr_req; CLEAR walks clr_ptr across every word once.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      CLEAR: begin
        // Natural wrap of the ADDR_WIDTH-bit pointer gives the modulo-DEPTH increment.
        clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
        if (clr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
      end
    endcase
    busy_d = (state_d == CLEAR);
  end

  // Single array write port shared by the clear engine and user writes; clear has priority.
  always_comb begin
    mem_we    = in_clear | wr_en;
    mem_waddr = in_clear ? clr_ptr_q : w_addr;
    mem_wdata = in_clear ? '0 : w_data;
    wr_drop_d = in_clear & wr_en;
  end

  // Read ports: hold when disabled, zero during clear, forward same-cycle write data in IDLE.
  always_comb begin
    r_data_a_d = r_data_a_q;
    r_data_b_d = r_data_b_q;
    if (rd_en_a) begin
      if (in_clear) begin
        r_data_a_d = '0;
      end else if (wr_en && (r_addr_a == w_addr)) begin
        r_data_a_d = w_data;
      end else begin
        r_data_a_d = mem_q[r_addr_a];
      end
    end
    if (rd_en_b) begin
      if (in_clear) begin
        r_data_b_d = '0;
      end else if (wr_en && (r_addr_b == w_addr)) begin
        r_data_b_d = w_data;
      end else begin
        r_data_b_d = mem_q[r_addr_b];
      end
    end
  end

  // Control and read registers; reset lands in CLEAR so the array is scrubbed after power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      busy_q     <= 1'b1;
      wr_drop_q  <= 1'b0;
      r_data_a_q <= '0;
      r_data_b_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      busy_q     <= busy_d;
      wr_drop_q  <= wr_drop_d;
      r_data_a_q <= r_data_a_d;
      r_data_b_q <= r_data_b_d;
    end
  end

  // Storage array is not reset; the post-reset clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign r_data_a = r_data_a_q;
  assign r_data_b = r_data_b_q;
  assign busy     = busy_q;
  assign wr_drop  = wr_drop_q;

endmodule
